// File: rtl/return_stack.sv
// return_stack: parametrised return-address stack with occupancy status, sticky
// overflow/underflow flags, optional circular overwrite, tail-replace and flush.
`default_nettype none

module return_stack #(
   parameter int PC_WIDTH         = 8,
   parameter int DEPTH            = 16,
   parameter int WRAP_ON_OVERFLOW = 0,
   parameter int CNT_WIDTH        = $clog2(DEPTH + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 call,
   input  logic                 ret,
   input  logic                 flush,
   input  logic [PC_WIDTH-1:0]  called_from,
   output logic [PC_WIDTH-1:0]  return_to,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 empty,
   output logic                 full,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int                 PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W-1:0]   PTR_MAX = PTR_W'(DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

   logic [PC_WIDTH-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]     wp_q, wp_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 ovf_q, ovf_d;
   logic                 unf_q, unf_d;

   logic                 we;
   logic [PTR_W-1:0]     waddr;
   logic [PTR_W-1:0]     wp_inc, wp_dec;
   logic [PC_WIDTH-1:0]  push_val;
   logic                 is_empty, is_full;

   assign wp_inc   = (wp_q == PTR_MAX) ? '0 : wp_q + 1'b1;
   assign wp_dec   = (wp_q == '0) ? PTR_MAX : wp_q - 1'b1;
   assign push_val = called_from + 1'b1;
   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_FULL);

   always_comb begin
      wp_d    = wp_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      we      = 1'b0;
      waddr   = wp_q;
      if (flush) begin
         wp_d    = '0;
         count_d = '0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end else begin
         case ({call, ret})
            2'b10: begin
               if (!is_full) begin
                  we      = 1'b1;
                  wp_d    = wp_inc;
                  count_d = count_q + 1'b1;
               end else begin
                  ovf_d = 1'b1;
                  // Circular mode sacrifices the oldest entry; count stays saturated.
                  if (WRAP_ON_OVERFLOW != 0) begin
                     we   = 1'b1;
                     wp_d = wp_inc;
                  end
               end
            end
            2'b01: begin
               if (!is_empty) begin
                  wp_d    = wp_dec;
                  count_d = count_q - 1'b1;
               end else begin
                  unf_d = 1'b1;
               end
            end
            2'b11: begin
               if (!is_empty) begin
                  we    = 1'b1;
                  waddr = wp_dec;
               end else begin
                  we      = 1'b1;
                  wp_d    = wp_inc;
                  count_d = count_q + 1'b1;
                  unf_d   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wp_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Storage needs no reset; entries are only visible while count is non-zero.
   always_ff @(posedge clock) begin
      if (reset && we) begin
         mem_q[waddr] <= push_val;
      end
   end

   assign return_to = is_empty ? '0 : mem_q[wp_dec];
   assign count     = count_q;
   assign empty     = is_empty;
   assign full      = is_full;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

`default_nettype wire
